// File: rtl/chained_updown_counter.sv
// Bank of N independent W-bit up/down counters that can be cascaded at run
// time into one N*W-bit counter (lane 0 least significant). Overflow either
// wraps or saturates, selected by SAT at elaboration.
module chained_updown_counter #(
  parameter int N   = 2,
  parameter int W   = 4,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             chain,
  input  logic [2*N-1:0]   op,
  input  logic [N*W-1:0]   load_val,
  output logic [N*W-1:0]   cnt,
  output logic [N-1:0]     ovf,
  output logic [N-1:0]     at_max,
  output logic [N-1:0]     at_zero
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_t;

  // A single lane has nothing to cascade into, so chain is ignored then.
  logic chain_mode;
  assign chain_mode = chain & (N > 1);

  logic [N*W-1:0] cnt_next;
  logic [N-1:0]   ovf_next;
  logic           all_max;
  logic           all_zero;

  // The whole cascaded value is at its limit only when every lane is.
  assign all_max  = &at_max;
  assign all_zero = &at_zero;

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam bit IS_TOP = (i == N - 1);

    logic [W-1:0] cur;
    logic [W-1:0] nxt;
    logic [1:0]   lane_op;
    logic         carry_in;
    logic         borrow_in;
    logic         step_up;
    logic         step_dn;
    logic         lim_up;
    logic         lim_dn;
    logic         flag_ok;
    logic         ovf_n;

    assign cur        = cnt[W*i +: W];
    assign at_max[i]  = &cur;
    assign at_zero[i] = ~|cur;

    // Carry/borrow into a lane comes from the current counts of all lower
    // lanes, so a lane steps only when everything below it rolls over.
    if (i == 0) begin : g_first
      assign carry_in  = 1'b1;
      assign borrow_in = 1'b1;
    end else begin : g_upper
      assign carry_in  = &at_max[i-1:0];
      assign borrow_in = &at_zero[i-1:0];
    end

    // In chain mode every lane follows lane 0's opcode and the limit test is
    // on the full value; only the top lane reports the overflow.
    assign lane_op = chain_mode ? op[1:0] : op[2*i +: 2];
    assign step_up = chain_mode ? carry_in  : 1'b1;
    assign step_dn = chain_mode ? borrow_in : 1'b1;
    assign lim_up  = chain_mode ? all_max   : at_max[i];
    assign lim_dn  = chain_mode ? all_zero  : at_zero[i];
    assign flag_ok = chain_mode ? IS_TOP    : 1'b1;

    // Per-lane next count and overflow flag; unknown opcodes fall to hold.
    always_comb begin
      nxt   = cur;
      ovf_n = 1'b0;
      case (lane_op)
        OP_LOAD: nxt = load_val[W*i +: W];
        OP_UP: begin
          if (step_up) begin
            if (!(lim_up && (SAT != 0))) nxt = cur + W'(1);
            ovf_n = lim_up & flag_ok;
          end
        end
        OP_DOWN: begin
          if (step_dn) begin
            if (!(lim_dn && (SAT != 0))) nxt = cur - W'(1);
            ovf_n = lim_dn & flag_ok;
          end
        end
        default: nxt = cur;
      endcase
    end

    assign cnt_next[W*i +: W] = nxt;
    assign ovf_next[i]        = ovf_n;
  end

  // Count and overflow registers; reset wins, and a disabled cycle holds the
  // count while dropping any overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= '0;
    end else if (!en) begin
      ovf <= '0;
    end else begin
      cnt <= cnt_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_chained_updown_counter.sv
// Directed bench for chained_updown_counter: a wrapping and a saturating
// instance (N=2, W=4) share the same stimulus; cnt is shown as {lane1,lane0}.
module tb_chained_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       chain;
  logic [3:0] op;
  logic [7:0] load_val;

  logic [7:0] cnt_w;
  logic [1:0] ovf_w;
  logic [1:0] max_w;
  logic [1:0] zero_w;
  logic [7:0] cnt_s;
  logic [1:0] ovf_s;
  logic [1:0] max_s;
  logic [1:0] zero_s;

  int checkCount;
  int errorCount;

  chained_updown_counter #(.N(2), .W(4), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .chain(chain), .op(op),
    .load_val(load_val), .cnt(cnt_w), .ovf(ovf_w),
    .at_max(max_w), .at_zero(zero_w)
  );

  chained_updown_counter #(.N(2), .W(4), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .chain(chain), .op(op),
    .load_val(load_val), .cnt(cnt_s), .ovf(ovf_s),
    .at_max(max_s), .at_zero(zero_s)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let outputs settle after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic c,
                               input logic [3:0] o, input logic [7:0] lv);
    rst      = r;
    en       = e;
    chain    = c;
    op       = o;
    load_val = lv;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b0; en = 1'b0; chain = 1'b0; op = 4'b0000; load_val = 8'h00;

    applyStimulus(1'b1, 1'b1, 1'b0, 4'b1010, 8'h00);
    checkOutput("rst_cnt",  cnt_w, 8'h00);
    checkOutput("rst_ovf",  {6'd0, ovf_w}, 8'h00);
    checkOutput("rst_zero", {6'd0, zero_w}, 8'h03);
    checkOutput("rst_max",  {6'd0, max_w}, 8'h00);
    checkOutput("rst_cnt_s", cnt_s, 8'h00);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0101, 8'h5A);
    checkOutput("load_5a", cnt_w, 8'h5A);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b1010, 8'h00);
    checkOutput("rst_mid", cnt_w, 8'h00);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0101, 8'h3E);
    checkOutput("load_3e", cnt_w, 8'h3E);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1110, 8'h00);
    checkOutput("ind1_cnt", cnt_w, 8'h2F);
    checkOutput("ind1_ovf", {6'd0, ovf_w}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1110, 8'h00);
    checkOutput("ind2_cnt", cnt_w, 8'h10);
    checkOutput("ind2_ovf", {6'd0, ovf_w}, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1110, 8'h00);
    checkOutput("ind3_cnt", cnt_w, 8'h01);
    checkOutput("ind3_ovf", {6'd0, ovf_w}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1100, 8'h00);
    checkOutput("ind4_cnt", cnt_w, 8'hF1);
    checkOutput("ind4_ovf", {6'd0, ovf_w}, 8'h02);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0101, 8'h0F);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0010, 8'h00);
    checkOutput("chn_carry", cnt_w, 8'h10);
    checkOutput("chn_carry_ovf", {6'd0, ovf_w}, 8'h00);
    checkOutput("chn_carry_s", cnt_s, 8'h10);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, 8'hFF);
    checkOutput("chn_load", cnt_w, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0010, 8'h00);
    checkOutput("chn_wrap", cnt_w, 8'h00);
    checkOutput("chn_wrap_ovf", {6'd0, ovf_w}, 8'h02);
    checkOutput("chn_sat", cnt_s, 8'hFF);
    checkOutput("chn_sat_ovf", {6'd0, ovf_s}, 8'h02);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 8'h00);
    checkOutput("chn_pulse_end", {6'd0, ovf_w}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0011, 8'h00);
    checkOutput("chn_under", cnt_w, 8'hFF);
    checkOutput("chn_under_ovf", {6'd0, ovf_w}, 8'h02);
    checkOutput("chn_under_max", {6'd0, max_w}, 8'h03);
    checkOutput("chn_dn_s", cnt_s, 8'hFE);
    checkOutput("chn_dn_s_ovf", {6'd0, ovf_s}, 8'h00);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0101, 8'h0F);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1110, 8'h00);
    checkOutput("sat1_cnt", cnt_s, 8'h0F);
    checkOutput("sat1_ovf", {6'd0, ovf_s}, 8'h03);
    checkOutput("wrp1_cnt", cnt_w, 8'hF0);
    checkOutput("wrp1_ovf", {6'd0, ovf_w}, 8'h03);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1110, 8'h00);
    checkOutput("sat2_cnt", cnt_s, 8'h0F);
    checkOutput("sat2_ovf", {6'd0, ovf_s}, 8'h03);
    checkOutput("wrp2_cnt", cnt_w, 8'hE1);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b1010, 8'h00);
      checkOutput("en0_cnt", cnt_w, 8'hE1);
      checkOutput("en0_cnt_s", cnt_s, 8'h0F);
      checkOutput("en0_ovf_s", {6'd0, ovf_s}, 8'h00);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0100, 8'hAA);
    checkOutput("ign_op_cnt", cnt_w, 8'hE1);
    checkOutput("ign_op_cnt_s", cnt_s, 8'h0F);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0101, 8'h2E);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010, 8'h00);
    checkOutput("mode_ind", cnt_w, 8'h2F);
    checkOutput("mode_ind_max", {6'd0, max_w}, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0010, 8'h00);
    checkOutput("mode_chain", cnt_w, 8'h30);
    checkOutput("mode_chain_ovf", {6'd0, ovf_w}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010, 8'h00);
    checkOutput("mode_back", cnt_w, 8'h31);
    checkOutput("mode_back_s", cnt_s, 8'h31);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/chained_updown_counter.md
Name: chained_updown_counter

Overview:
- Parametrised bank of N independent W-bit up/down counters with per-lane 2-bit opcodes: hold, load, up, down.
- Lanes can be cascaded at run time into a single N*W-bit counter, with carry/borrow rippled through a generate chain.
- Overflow handling is selectable at elaboration: wrap or saturate.
- Serves as the generic event/loop counter for datapath and testbench sequencing blocks.

Parameters:
N, 2, number of lanes (≥1)
W, 4, bits per lane (≥1)
SAT, 0, 0 = wrap-around on overflow/underflow; 1 = saturate at limits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  global count enable; 0 = all lanes hold
chain  input  1  0 = independent lanes; 1 = lanes cascaded, lane 0 least significant
op  input  2*N  opcode per lane; lane i = op[2i+1:2i]
load_val  input  N*W  load value; lane i = load_val[W*i+W-1:W*i]
cnt  output  N*W  registered count; lane i = cnt[W*i+W-1:W*i]
ovf  output  N  registered overflow/underflow flag per lane
at_max  output  N  combinational; lane i count == all ones
at_zero  output  N  combinational; lane i count == 0

Behaviour:
- Reset (rst=1 at a rising edge): cnt=0, ovf=0. Reset has priority over en, chain and op. Any operation in flight is discarded. After reset: at_zero = all ones, at_max = 0.
- Opcodes (case per lane):
  - 2'b00 hold.
  - 2'b01 load lane from load_val.
  - 2'b10 up by 1.
  - 2'b11 down by 1.
- en=0: all lanes hold; ovf cleared to 0 on that edge.
- Latency: one cycle. New cnt and ovf are visible together after the edge. ovf is a 1-cycle pulse aligned with the cnt value that results from the overflow.
- Independent mode (chain=0):
  - Each lane obeys its own op.
  - SAT=0: up at all-ones gives 0; down at 0 gives all-ones. Both set ovf[i]=1 for that cycle.
  - SAT=1: up at all-ones and down at 0 hold the value. ovf[i]=1 on every such attempted step.
  - Load and hold set ovf[i]=0.
- Chain mode (chain=1):
  - Only op[1:0] is honoured; op[2N-1:2] is ignored.
  - Load: every lane loads its own slice of load_val in the same cycle.
  - Up: lane 0 increments. Lane i>0 increments iff all lanes below i are at_max (carry computed from current cnt, not next).
  - Down: lane 0 decrements. Lane i>0 decrements iff all lanes below i are at_zero.
  - SAT=0: full N*W value wraps. SAT=1: full value holds at all-ones (up) or 0 (down).
  - ovf[N-1]=1 on full-chain overflow/underflow or saturation attempt. ovf[N-2:0] is always 0 in chain mode, including internal lane-to-lane carries.
- Mode switch: toggling chain never alters cnt. The new mode applies from the edge at which chain is sampled.
- N=1: chain has no effect; ovf[0] behaves as in independent mode.
- No X propagation: op values outside the decode (only possible with X/Z inputs) fall to default = hold.

Test Plan:
Instance N=2, W=4, SAT=0 unless stated; cnt shown as {lane1,lane0}.
1. Reset priority: rst=1 for 1 edge with en=1, op=4'b1010 → cnt=8'h00, ovf=2'b00, at_zero=2'b11. Second run: rst=1 with cnt=8'h5A mid-count → cnt=8'h00 next cycle.
2. Independent wrap: load 8'h3E, then en=1, chain=0, op=4'b1110 for 3 edges:
   - lane0 goes F, 0, 1; lane1 goes 2, 1, 0.
   - ovf=2'b01 only on the cycle lane0 shows 0.
   - One further down edge on lane1 → lane1=F, ovf[1]=1.
3. Chain carry: load 8'h0F, chain=1, op[1:0]=up → cnt=8'h10, ovf=0. Load 8'hFF, up → cnt=8'h00, ovf=2'b10 for 1 cycle. Down from 8'h00 → 8'hFF, ovf=2'b10.
4. SAT=1 instance:
   - Independent: lane0=F, up ×2 → lane0 stays F, ovf[0]=1 both cycles. lane1=0, down → stays 0, ovf[1]=1.
   - Chain: cnt=8'hFF, up → stays 8'hFF, ovf=2'b10.
5. Enable/ignored ops:
   - en=0 with op=4'b1010 for 4 edges → cnt unchanged, ovf=0.
   - chain=1 with op[3:2]=2'b01 and op[1:0]=hold → no load occurs.
6. Mode toggle: count to 8'h2F independently, then assert chain with up → 8'h30. Deassert chain with op=4'b0010 → 8'h31; lane1 unaffected.
